// File: rtl/accum_pkg.sv
// accum_pkg: shared width and state encoding for the batch accumulator
package accum_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} accum_state_t;
endpackage

// File: rtl/adder_8bit.sv
// adder_8bit: combinational unsigned adder with carry-in and carry-out
module adder_8bit
  import accum_pkg::*;
(
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 carry_in,
  output logic [DATA_BITS-1:0] sum,
  output logic                 overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{DATA_BITS{1'b0}}, carry_in};
endmodule

// File: rtl/batch_accumulator.sv
// batch_accumulator: folds BATCH_LEN operands into a wrapping sum with sticky overflow, presented on a valid/ready output
module batch_accumulator
  import accum_pkg::*;
#(
  parameter int BATCH_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_sum,
  output logic                 out_overflow
);
  localparam int CW = $clog2(BATCH_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BATCH_LEN - 1);
  accum_state_t state_q;
  logic [DATA_BITS-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d, carry;
  logic [CW-1:0] cnt_q;
  adder_8bit u_add (
    .a(acc_q),
    .b(in_data),
    .carry_in(1'b0),
    .sum(acc_d),
    .overflow(carry)
  );
  assign ovf_d = ovf_q | carry;
  // Outputs decode straight from state and registers, so no input reaches them combinationally
  assign in_ready = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_sum = acc_q;
  assign out_overflow = ovf_q;
  // Batch FSM: accumulate until the terminal accept, hold until consumed; clear only aborts an open batch
  always_ff @(posedge clk) begin
    if (rst || (state_q == HOLD ? out_ready : clear)) begin
      state_q <= IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q != HOLD && in_valid) begin
      state_q <= cnt_q == LAST ? HOLD : ACCUM;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: tb/tb_batch_accumulator.sv
// tb_batch_accumulator: directed checks of batching, overflow, backpressure, clear, reset and BATCH_LEN=1
module tb_batch_accumulator;
  logic clk = 0, rst = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_overflow;
  logic [7:0] out_sum;
  logic b_in_valid = 0, b_out_ready = 1;
  logic [7:0] b_in_data = 0;
  logic b_in_ready, b_out_valid, b_out_overflow;
  logic [7:0] b_out_sum;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  batch_accumulator #(.BATCH_LEN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_overflow(out_overflow)
  );
  batch_accumulator #(.BATCH_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_overflow(b_out_overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic [7:0] v);
    in_valid = 1;
    in_data = v;
    step();
  endtask
  task automatic batch(input string tag, input logic [7:0] a, b, c, d, input logic [7:0] s, input logic o);
    feed(a);
    chk({tag, "_v1"}, out_valid, 0);
    feed(b);
    feed(c);
    chk({tag, "_v3"}, out_valid, 0);
    feed(d);
    in_valid = 0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_ovf"}, out_overflow, o);
  endtask
  task automatic handshake(input string tag);
    out_ready = 1;
    step();
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_ready"}, in_ready, 1);
    chk({tag, "_hs_sum"}, out_sum, 0);
  endtask
  initial begin
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_overflow, 0);
    out_ready = 1;
    batch("basic", 10, 20, 30, 40, 100, 0);
    handshake("basic");
    batch("ovf1", 200, 100, 0, 0, 44, 1);
    handshake("ovf1");
    batch("ovf2", 255, 1, 0, 0, 0, 1);
    handshake("ovf2");
    batch("ovf3", 1, 1, 1, 1, 4, 0);
    handshake("ovf3");
    out_ready = 0;
    batch("bp", 1, 2, 3, 4, 10, 0);
    in_valid = 1;
    in_data = 7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", out_sum, 10);
    end
    out_ready = 1;
    step();
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_sum", out_sum, 0);
    step();
    in_valid = 0;
    chk("bp_took7", out_sum, 7);
    feed(0);
    feed(0);
    feed(0);
    in_valid = 0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_sum", out_sum, 7);
    handshake("bp_next");
    feed(50);
    feed(60);
    chk("clr_pre_sum", out_sum, 110);
    clear = 1;
    in_data = 70;
    step();
    clear = 0;
    in_valid = 0;
    chk("clr_ready", in_ready, 1);
    chk("clr_sum", out_sum, 0);
    chk("clr_valid", out_valid, 0);
    out_ready = 0;
    batch("clr_next", 1, 2, 3, 4, 10, 0);
    clear = 1;
    step();
    clear = 0;
    chk("clr_hold_valid", out_valid, 1);
    chk("clr_hold_sum", out_sum, 10);
    handshake("clr_hold");
    feed(9);
    feed(9);
    in_valid = 0;
    chk("rmid_pre_sum", out_sum, 18);
    rst = 1;
    step();
    rst = 0;
    chk("rmid_sum", out_sum, 0);
    chk("rmid_ready", in_ready, 1);
    out_ready = 0;
    batch("rhold", 100, 100, 100, 0, 44, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rhold_valid", out_valid, 0);
    chk("rhold_sum", out_sum, 0);
    chk("rhold_ovf", out_overflow, 0);
    chk("rhold_ready", in_ready, 1);
    out_ready = 1;
    batch("rpost", 3, 4, 5, 6, 18, 0);
    handshake("rpost");
    for (int i = 0; i < 4; i++) begin
      feed(5);
      in_valid = 0;
      if (i < 3) begin
        chk("gap_valid", out_valid, 0);
        repeat (3) step();
        chk("gap_stall_sum", out_sum, 8'(5 * (i + 1)));
      end
    end
    chk("gap_valid_end", out_valid, 1);
    chk("gap_sum", out_sum, 20);
    handshake("gap");
    b_in_valid = 1;
    b_in_data = 42;
    step();
    b_in_valid = 0;
    chk("b1_valid", b_out_valid, 1);
    chk("b1_ready", b_in_ready, 0);
    chk("b1_sum", b_out_sum, 42);
    step();
    chk("b1_hs_valid", b_out_valid, 0);
    b_in_valid = 1;
    b_in_data = 200;
    step();
    b_in_valid = 0;
    chk("b2_valid", b_out_valid, 1);
    chk("b2_sum", b_out_sum, 200);
    chk("b2_ovf", b_out_overflow, 0);
    step();
    chk("b2_hs_valid", b_out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
